// File: rtl/uart_sync_fifo.sv
// Synchronous UART TX/RX buffer: FWFT (0-cycle) or registered (1-cycle) read, level and threshold flags.
// A write at full is taken only alongside an accepted read; rejected reads/writes set sticky error flags.
module uart_sync_fifo #(
  parameter int DATA_WIDTH          = 8,
  parameter int ADDR_WIDTH          = 4,
  parameter int FWFT                = 1,
  parameter int ALMOST_FULL_THRESH  = 14,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic                  o_underflow,
  output logic [ADDR_WIDTH:0]   o_level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] LVL_AE   = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] LVL_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  if (ALMOST_FULL_THRESH <= 0 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_af
    $error("uart_sync_fifo: ALMOST_FULL_THRESH out of range");
  end
  if (ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH >= DEPTH) begin : g_bad_ae
    $error("uart_sync_fifo: ALMOST_EMPTY_THRESH out of range");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_set;
  logic                  udf_set;

  // Flags decode only the registered level, never same-cycle requests.
  assign o_full         = (level == LVL_FULL);
  assign o_empty        = (level == '0);
  assign o_almost_full  = (level >= LVL_AF);
  assign o_almost_empty = (level <= LVL_AE);
  assign o_level        = level;
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

  assign rd_acc  = i_rd_en && !o_empty;
  assign wr_acc  = i_wr_en && (!o_full || rd_acc);
  assign ovf_set = i_wr_en && !wr_acc && !i_flush;
  assign udf_set = i_rd_en && !rd_acc && !i_flush;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush && wr_acc) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_acc && !rd_acc) begin
        level <= level + LVL_ONE;
      end else if (rd_acc && !wr_acc) begin
        level <= level - LVL_ONE;
      end
    end
  end

  // A new error in the same cycle as a clear wins over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set)        overflow_q <= 1'b1;
      else if (i_clr_err) overflow_q <= 1'b0;
      if (udf_set)        underflow_q <= 1'b1;
      else if (i_clr_err) underflow_q <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign o_rd_data  = mem[rd_ptr];
    assign o_rd_valid = !o_empty;
  end else begin : g_reg_rd
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (i_flush) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr];
      end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Bench for uart_sync_fifo: FWFT and registered-read instances share stimulus and a queue-based model.
module tb_uart_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n, flush, clr, wr_en, rd_en;
  logic [7:0] wr_data;

  logic       f1_full, f1_af, f1_ovf, f1_rv, f1_empty, f1_ae, f1_udf;
  logic [7:0] f1_rd;
  logic [4:0] f1_lvl;
  logic       f0_full, f0_af, f0_ovf, f0_rv, f0_empty, f0_ae, f0_udf;
  logic [7:0] f0_rd;
  logic [4:0] f0_lvl;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_udf, m_v0;
  logic [7:0] m_d0;

  always #5 clk = ~clk;

  uart_sync_fifo #(.FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_clr_err(clr),
    .i_wr_en(wr_en), .i_wr_data(wr_data), .o_full(f1_full), .o_almost_full(f1_af),
    .o_overflow(f1_ovf), .i_rd_en(rd_en), .o_rd_data(f1_rd), .o_rd_valid(f1_rv),
    .o_empty(f1_empty), .o_almost_empty(f1_ae), .o_underflow(f1_udf), .o_level(f1_lvl)
  );

  uart_sync_fifo #(.FWFT(0)) dut_reg (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_clr_err(clr),
    .i_wr_en(wr_en), .i_wr_data(wr_data), .o_full(f0_full), .o_almost_full(f0_af),
    .o_overflow(f0_ovf), .i_rd_en(rd_en), .o_rd_data(f0_rd), .o_rd_valid(f0_rv),
    .o_empty(f0_empty), .o_almost_empty(f0_ae), .o_underflow(f0_udf), .o_level(f0_lvl)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of words plus the sticky flags and the registered-read output.
  task automatic model_edge();
    logic r, w;
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_v0 = 1'b0; m_d0 = 8'h00;
    end else if (flush) begin
      q.delete();
      m_v0 = 1'b0;
      if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      r = rd_en && (q.size() > 0);
      w = wr_en && (q.size() < 16 || r);
      m_ovf = (wr_en && !w) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = (rd_en && !r) ? 1'b1 : (clr ? 1'b0 : m_udf);
      m_v0 = r;
      if (r) m_d0 = q.pop_front();
      if (w) q.push_back(wr_data);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("level_fwft", f1_lvl, n);
    chk("level_reg", f0_lvl, n);
    chk("full", {f1_full, f0_full}, {2{n == 16}});
    chk("almost_full", {f1_af, f0_af}, {2{n >= 14}});
    chk("empty", {f1_empty, f0_empty}, {2{n == 0}});
    chk("almost_empty", {f1_ae, f0_ae}, {2{n <= 2}});
    chk("overflow", {f1_ovf, f0_ovf}, {2{m_ovf}});
    chk("underflow", {f1_udf, f0_udf}, {2{m_udf}});
    chk("fwft_valid", f1_rv, n > 0);
    if (n > 0) chk("fwft_data", f1_rd, q[0]);
    chk("reg_valid", f0_rv, m_v0);
    chk("reg_data", f0_rd, m_d0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r_n, input logic f, input logic c, input logic w,
                       input logic [7:0] d, input logic rd);
    rst_n = r_n; flush = f; clr = c; wr_en = w; wr_data = d; rd_en = rd;
  endtask

  typedef struct {
    logic       rst_n, flush, clr, wr;
    logic [7:0] wd;
    logic       rd;
    logic [4:0] lvl;
    logic       ovf, udf, v0;
    logic [7:0] d0;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00};
    vecs[1]  = '{1, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    vecs[2]  = '{1, 0, 0, 1, 8'hA5, 0, 1, 0, 0, 0, 8'h00};
    vecs[3]  = '{1, 0, 0, 1, 8'h5A, 0, 2, 0, 0, 0, 8'h00};
    vecs[4]  = '{1, 0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'hA5};
    vecs[5]  = '{1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'hA5};
    vecs[6]  = '{1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h5A};
    vecs[7]  = '{1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A};
    vecs[8]  = '{1, 0, 0, 1, 8'h33, 1, 1, 0, 1, 0, 8'h5A};
    vecs[9]  = '{1, 0, 0, 1, 8'h44, 1, 1, 0, 1, 1, 8'h33};
    vecs[10] = '{1, 0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h44};
    vecs[11] = '{1, 1, 0, 1, 8'h77, 0, 0, 0, 0, 0, 8'h44};
    vecs[12] = '{1, 1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h44};
    vecs[13] = '{1, 0, 0, 1, 8'h99, 0, 1, 0, 0, 0, 8'h44};
    vecs[14] = '{0, 0, 0, 1, 8'h11, 0, 0, 0, 0, 0, 8'h00};

    drive(0, 0, 0, 0, 8'h00, 0);
    step();
    step();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].clr, vecs[i].wr, vecs[i].wd, vecs[i].rd);
      step();
      chk($sformatf("vec%0d_level", i), f0_lvl, vecs[i].lvl);
      chk($sformatf("vec%0d_ovf", i), f0_ovf, vecs[i].ovf);
      chk($sformatf("vec%0d_udf", i), f0_udf, vecs[i].udf);
      chk($sformatf("vec%0d_rvalid", i), f0_rv, vecs[i].v0);
      chk($sformatf("vec%0d_rdata", i), f0_rd, vecs[i].d0);
    end

    // Fill 0x01..0x10, then one write too many.
    drive(0, 0, 0, 0, 8'h00, 0);
    step();
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, 0, 1, 8'(i), 0);
      step();
      chk("fill_level", f1_lvl, i);
      chk("fill_af", f1_af, i >= 14);
      chk("fill_full", f1_full, i == 16);
    end
    drive(1, 0, 0, 1, 8'hFF, 0);
    step();
    chk("extra_wr_ovf", f1_ovf, 1'b1);
    chk("extra_wr_level", f1_lvl, 16);

    // Write and read together at full; 0xEE must come out 16th after the wrap.
    drive(1, 0, 1, 0, 8'h00, 0);
    step();
    drive(1, 0, 0, 1, 8'hEE, 1);
    step();
    chk("full_rw_level", f1_lvl, 16);
    chk("full_rw_ovf", f1_ovf, 1'b0);
    chk("full_rw_d0", f0_rd, 8'h01);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = (i < 15) ? 8'(i + 2) : 8'hEE;
      drive(1, 0, 0, 0, 8'h00, 1);
      chk("drain_fwft_head", f1_rd, e);
      step();
      chk("drain_reg_data", f0_rd, e);
      chk("drain_ae", f1_ae, (15 - i) <= 2);
    end
    chk("drain_empty", f1_empty, 1'b1);
    drive(1, 0, 0, 0, 8'h00, 1);
    step();
    chk("extra_rd_udf", f1_udf, 1'b1);

    // Flush at level 5 with a prior overflow.
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 1, 8'(8'h40 + i), 0);
      step();
    end
    for (int i = 0; i < 11; i++) begin
      drive(1, 0, 0, 0, 8'h00, 1);
      step();
    end
    chk("pre_flush_level", f1_lvl, 5);
    drive(1, 1, 0, 1, 8'hBB, 0);
    step();
    chk("flush_level", f1_lvl, 0);
    chk("flush_empty", f1_empty, 1'b1);
    chk("flush_ovf_kept", f1_ovf, 1'b1);
    drive(1, 0, 1, 0, 8'h00, 0);
    step();
    chk("clr_ovf", f1_ovf, 1'b0);

    // Reset at level 7 with a write pending.
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 1, 8'(8'h70 + i), 0);
      step();
    end
    drive(0, 0, 0, 1, 8'hCC, 0);
    step();
    chk("rst_level", f1_lvl, 0);
    chk("rst_empty", f1_empty, 1'b1);
    chk("rst_ae", f1_ae, 1'b1);
    chk("rst_ovf", f1_ovf, 1'b0);

    // Random traffic in phases that bias towards fill, drain and balance.
    for (int n = 0; n < 3000; n++) begin
      int wp;
      wp = (n / 200) % 3 == 0 ? 85 : ((n / 200) % 3 == 1 ? 20 : 50);
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 99) < wp,
            8'($urandom), $urandom_range(0, 99) < (100 - wp));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
